// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared constants for the registered ALU (ula_seq) and its single-cycle
// combinational core (ula_seq_comb).
//   - Opcode values OP_ADD..OP_MUL. Any opcode above OP_MUL is illegal.
//   - FSM state encoding ST_IDLE / ST_MUL / ST_HOLD.
//   - Bit positions of the Z/C/V flags inside the packed flag vector.
// -----------------------------------------------------------------------------
package ula_pkg;

  // Opcodes are compared as unsigned integers, so they work for any opcode width.
  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_NEG = 2;
  localparam int unsigned OP_EQ  = 3;
  localparam int unsigned OP_GT  = 4;
  localparam int unsigned OP_LT  = 5;
  localparam int unsigned OP_AND = 6;
  localparam int unsigned OP_XOR = 7;
  localparam int unsigned OP_OR  = 8;
  localparam int unsigned OP_SHL = 9;
  localparam int unsigned OP_SHR = 10;
  localparam int unsigned OP_MUL = 11;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Positions of the flags inside the packed flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage

// File: rtl/ula_seq_comb.sv
// -----------------------------------------------------------------------------
// ula_seq_comb
// Purely combinational core for every single-cycle operation: it produces the
// W-bit result, the Z/C/V flags, the next sticky compare status and the
// illegal-opcode indication. MUL is not computed here. The top builds MUL from
// its shift-add accumulator and ignores this block's outputs for that opcode.
// Ports:
//   op_i      in   OPW       operation code
//   x_i, y_i  in   W         operands (unsigned)
//   status_i  in   1         current sticky status; passed through unless compare
//   result_o  out  W         operation result
//   flags_o   out  FLAG_N    {V, C, Z} at positions FLAG_V / FLAG_C / FLAG_Z
//   status_o  out  1         next sticky status
//   err_o     out  1         opcode is illegal
// -----------------------------------------------------------------------------
module ula_seq_comb
  import ula_pkg::*;
#(
  parameter int W   = 4,
  parameter int OPW = 4
) (
  input  logic [OPW-1:0]    op_i,
  input  logic [W-1:0]      x_i,
  input  logic [W-1:0]      y_i,
  input  logic              status_i,
  output logic [W-1:0]      result_o,
  output logic [FLAG_N-1:0] flags_o,
  output logic              status_o,
  output logic              err_o
);

  // The most negative two's-complement value. Negating it overflows.
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W:0]  wide_w;   // W+1 bits: carry/borrow out, or the bit shifted out
  logic        cmp;
  logic        is_cmp;
  int unsigned op_n;

  always_comb begin
    // NOTE: every output and temporary gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    result_o = '0;
    flags_o  = '0;
    status_o = status_i;
    err_o    = 1'b0;
    wide_w   = '0;
    cmp      = 1'b0;
    is_cmp   = 1'b0;
    op_n     = 32'(op_i);

    case (op_n)
      OP_ADD: begin
        wide_w          = {1'b0, x_i} + {1'b0, y_i};
        result_o        = wide_w[W-1:0];
        flags_o[FLAG_C] = wide_w[W];
        flags_o[FLAG_V] = (x_i[W-1] == y_i[W-1]) && (result_o[W-1] != x_i[W-1]);
      end
      OP_SUB: begin
        wide_w          = {1'b0, x_i} - {1'b0, y_i};
        result_o        = wide_w[W-1:0];
        flags_o[FLAG_C] = ~wide_w[W];  // C means no borrow
        flags_o[FLAG_V] = (x_i[W-1] != y_i[W-1]) && (result_o[W-1] != x_i[W-1]);
      end
      OP_NEG: begin
        result_o        = '0 - y_i;
        flags_o[FLAG_V] = (y_i == MIN_NEG);
      end
      OP_EQ: begin
        cmp    = (x_i == y_i);
        is_cmp = 1'b1;
      end
      OP_GT: begin
        cmp    = (x_i > y_i);
        is_cmp = 1'b1;
      end
      OP_LT: begin
        cmp    = (x_i < y_i);
        is_cmp = 1'b1;
      end
      OP_AND: result_o = x_i & y_i;
      OP_XOR: result_o = x_i ^ y_i;
      OP_OR:  result_o = x_i | y_i;
      OP_SHL: begin
        // The full y value is the shift amount, so amounts >= W give 0.
        // The extra top bit catches the last bit shifted out.
        wide_w          = {1'b0, x_i} << y_i;
        result_o        = wide_w[W-1:0];
        flags_o[FLAG_C] = wide_w[W];
      end
      OP_SHR: begin
        wide_w          = {x_i, 1'b0} >> y_i;
        result_o        = wide_w[W:1];
        flags_o[FLAG_C] = wide_w[0];
      end
      OP_MUL: ;  // built by the top's shift-add sequencer
      default: err_o = 1'b1;
    endcase

    if (is_cmp) begin
      result_o = {{(W-1){1'b0}}, cmp};
      status_o = cmp;
    end

    // An illegal opcode reports all flags as 0. Every other op sets Z from its final result.
    if (!err_o) begin
      flags_o[FLAG_Z] = (result_o == '0);
    end
  end

endmodule

// File: rtl/ula_seq.sv
// -----------------------------------------------------------------------------
// ula_seq
// Registered ALU with valid/ready handshakes on its input and its output.
// Single-cycle ops are computed by ula_seq_comb and registered on acceptance.
// MUL runs a W-cycle shift-add: one partial product per cycle, LSB of y first.
// Results, flags, err and the sticky status stay stable in HOLD until the
// consumer takes them.
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    op/operands valid
//   in_ready   out  1    high only in IDLE
//   op         in   OPW  operation code
//   x, y       in   W    operands
//   out_valid  out  1    result/flags valid (HOLD)
//   out_ready  in   1    consumer takes result
//   result     out  W    registered result
//   status     out  1    sticky compare result (EQ/GT/LT only)
//   flag_z/c/v out  1    zero / carry / overflow flags
//   err        out  1    illegal opcode on this result
// -----------------------------------------------------------------------------
module ula_seq
  import ula_pkg::*;
#(
  parameter int W   = 4,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           status,
  output logic           flag_z,
  output logic           flag_c,
  output logic           flag_v,
  output logic           err
);

  // Holds the MUL step index 0..W-1. W >= 2, so this is at least 1 bit.
  localparam int CW = $clog2(W);

  logic [1:0]        state_q,  state_d;
  logic [W-1:0]      result_q, result_d;
  logic              status_q, status_d;
  logic [FLAG_N-1:0] flags_q,  flags_d;
  logic              err_q,    err_d;

  // Shift-add multiplier: the multiplicand shifts left and the multiplier shifts right.
  logic [2*W-1:0]    acc_q,    acc_d;
  logic [2*W-1:0]    mcand_q,  mcand_d;
  logic [W-1:0]      mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [2*W-1:0]    acc_step;

  logic [W-1:0]      c_result;
  logic [FLAG_N-1:0] c_flags;
  logic              c_status;
  logic              c_err;

  ula_seq_comb #(
    .W   (W),
    .OPW (OPW)
  ) u_comb (
    .op_i     (op),
    .x_i      (x),
    .y_i      (y),
    .status_i (status_q),
    .result_o (c_result),
    .flags_o  (c_flags),
    .status_o (c_status),
    .err_o    (c_err)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    flags_d  = flags_q;
    err_d    = err_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (32'(op) == OP_MUL) begin
            state_d  = ST_MUL;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, x};
            mplier_d = y;
            cnt_d    = '0;
          end else begin
            state_d  = ST_HOLD;
            result_d = c_result;
            flags_d  = c_flags;
            status_d = c_status;
            err_d    = c_err;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // On the last partial product, register the final sum directly into the result.
        if (cnt_q == CW'(W - 1)) begin
          state_d         = ST_HOLD;
          result_d        = acc_step[W-1:0];
          flags_d         = '0;
          flags_d[FLAG_Z] = (acc_step[W-1:0] == '0);
          flags_d[FLAG_V] = |acc_step[2*W-1:W];
          err_d           = 1'b0;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      status_q <= 1'b0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from the values present before the clock edge.
      state_q  <= state_d;
      result_q <= result_d;
      status_q <= status_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign status    = status_q;
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign err       = err_q;

endmodule

// File: tb/tb_ula_seq.sv
// -----------------------------------------------------------------------------
// tb_ula_seq
// Self-checking bench for ula_seq. A W=4 instance is checked on every cycle
// that out_valid is high, against an arithmetic model fed from an expectation
// queue. Directed literal checks pin both the model and the DUT. A W=8
// instance covers the wide shift-amount cases.
// -----------------------------------------------------------------------------
module tb_ula_seq;
  import ula_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W=4 instance
  logic       in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0] op4 = '0, x4 = '0, y4 = '0;
  logic       in_ready4, out_valid4, status4, fz4, fc4, fv4, err4;
  logic [3:0] result4;

  // W=8 instance
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [3:0] op8 = '0;
  logic [7:0] x8 = '0, y8 = '0;
  logic       in_ready8, out_valid8, status8, fz8, fc8, fv8, err8;
  logic [7:0] result8;

  ula_seq #(.W(4), .OPW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
    .x(x4), .y(y4), .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .status(status4), .flag_z(fz4), .flag_c(fc4), .flag_v(fv4), .err(err4)
  );

  ula_seq #(.W(8), .OPW(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .status(status8), .flag_z(fz8), .flag_c(fc8), .flag_v(fv8), .err(err8)
  );

  typedef struct {
    int result;
    int status;
    int z;
    int c;
    int v;
    int err;
  } exp_t;

  exp_t q4[$];
  int   status_m = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the ALU rules, using plain integer arithmetic.
  function automatic exp_t model(input int w, input int op, input int x, input int y, input int st);
    exp_t e;
    int   m    = 1 << w;
    int   half = m / 2;
    int   sx   = (x >= half) ? x - m : x;
    int   sy   = (y >= half) ? y - m : y;
    int   s;
    e = '{result: 0, status: st, z: 0, c: 0, v: 0, err: 0};
    case (op)
      0: begin
        s = x + y; e.result = s % m; e.c = int'(s >= m);
        s = sx + sy; e.v = int'(s >= half || s < -half);
      end
      1: begin
        e.result = (x - y + m) % m; e.c = int'(x >= y);
        s = sx - sy; e.v = int'(s >= half || s < -half);
      end
      2: begin
        e.result = (m - y) % m;
        s = -sy; e.v = int'(s >= half);
      end
      3: begin e.result = int'(x == y); e.status = e.result; end
      4: begin e.result = int'(x > y);  e.status = e.result; end
      5: begin e.result = int'(x < y);  e.status = e.result; end
      6: e.result = x & y;
      7: e.result = x ^ y;
      8: e.result = x | y;
      9: begin
        e.result = (y >= w) ? 0 : (x << y) % m;
        e.c = (y >= 1 && y <= w) ? (x >> (w - y)) & 1 : 0;
      end
      10: begin
        e.result = (y >= w) ? 0 : (x >> y);
        e.c = (y >= 1 && y <= w) ? (x >> (y - 1)) & 1 : 0;
      end
      11: begin
        s = x * y; e.result = s % m; e.v = int'(s >= m);
      end
      default: e.err = 1;
    endcase
    if (e.err == 0) e.z = int'(e.result == 0);
    return e;
  endfunction

  // Compare process: checks the W=4 outputs on every cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst && out_valid4) begin
      if (q4.size() == 0) begin
        check("cmp_unexpected_valid", 32'(out_valid4), 0);
      end else begin
        check("cmp_result", 32'(result4), q4[0].result);
        check("cmp_status", 32'(status4), q4[0].status);
        check("cmp_z",      32'(fz4),     q4[0].z);
        check("cmp_c",      32'(fc4),     q4[0].c);
        check("cmp_v",      32'(fv4),     q4[0].v);
        check("cmp_err",    32'(err4),    q4[0].err);
        if (out_ready4) void'(q4.pop_front());
      end
    end
  end

  // All stimulus tasks start and finish 1 time unit after a rising edge.
  task automatic issue4(input int op, input int x, input int y);
    exp_t e;
    int   n = 0;
    while (!in_ready4 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("accept_timeout", 32'(in_ready4), 1);
    op4 = 4'(op); x4 = 4'(x); y4 = 4'(y); in_valid4 = 1'b1;
    e = model(4, op, x, y, status_m);
    status_m = e.status;
    q4.push_back(e);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic wait_valid4(input string name, input int exp_lat);
    int lat = 1;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check(name, lat, exp_lat);
  endtask

  task automatic take4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic run4(input int op, input int x, input int y);
    issue4(op, x, y);
    wait_valid4("latency", (op == int'(OP_MUL)) ? 5 : 1);
    take4();
  endtask

  task automatic run8(input int op, input int x, input int y,
                      input int exp_res, input int exp_c);
    op8 = 4'(op); x8 = 8'(x); y8 = 8'(y); in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_valid",  32'(out_valid8), 1);
    check("w8_result", 32'(result8), exp_res);
    check("w8_c",      32'(fc8), exp_c);
    check("w8_z",      32'(fz8), int'(exp_res == 0));
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pm;
    int   pairs_x[3] = '{6, 15, 8};
    int   pairs_y[3] = '{3, 1, 8};

    // Hand-computed expectations that pin the model itself.
    pm = model(4, OP_ADD, 7, 9, 0);
    check("model_add_res", pm.result, 0);
    check("model_add_c", pm.c, 1);
    pm = model(4, OP_MUL, 15, 15, 0);
    check("model_mul_res", pm.result, 1);
    check("model_mul_v", pm.v, 1);
    pm = model(8, OP_SHL, 1, 9, 0);
    check("model_shl8_res", pm.result, 0);

    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid4), 0);
    check("rst_result", 32'(result4), 0);
    check("rst_status", 32'(status4), 0);
    check("rst_flags", {29'd0, fv4, fc4, fz4}, 0);
    check("rst_err", 32'(err4), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready4), 1);

    // ADD 7+9
    issue4(OP_ADD, 7, 9);
    wait_valid4("add_latency", 1);
    check("add_result", 32'(result4), 0);
    check("add_c", 32'(fc4), 1);
    check("add_z", 32'(fz4), 1);
    check("add_v", 32'(fv4), 0);
    take4();

    // SUB 3-5
    issue4(OP_SUB, 3, 5);
    wait_valid4("sub_latency", 1);
    check("sub_result", 32'(result4), 14);
    check("sub_c", 32'(fc4), 0);
    take4();

    // MUL 5*3: out_valid exactly W+1 cycles after acceptance
    issue4(OP_MUL, 5, 3);
    wait_valid4("mul_latency", 5);
    check("mul_result", 32'(result4), 15);
    check("mul_v", 32'(fv4), 0);
    take4();

    // MUL 15*15
    issue4(OP_MUL, 15, 15);
    wait_valid4("mul2_latency", 5);
    check("mul2_result", 32'(result4), 1);
    check("mul2_v", 32'(fv4), 1);
    take4();

    // GT 9>4, then AND 12&10 keeps status
    issue4(OP_GT, 9, 4);
    wait_valid4("gt_latency", 1);
    check("gt_status", 32'(status4), 1);
    check("gt_result", 32'(result4), 1);
    take4();
    issue4(OP_AND, 12, 10);
    wait_valid4("and_latency", 1);
    check("and_result", 32'(result4), 8);
    check("and_status", 32'(status4), 1);
    take4();

    // Backpressure: hold 3 cycles while offering another op
    issue4(OP_XOR, 5, 3);
    wait_valid4("bp_latency", 1);
    for (int i = 0; i < 3; i++) begin
      op4 = 4'(OP_OR); x4 = 4'd12; y4 = 4'd3; in_valid4 = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready", 32'(in_ready4), 0);
      check("bp_out_valid", 32'(out_valid4), 1);
      check("bp_result", 32'(result4), 6);
    end
    in_valid4 = 1'b0;
    take4();
    check("bp_after_valid", 32'(out_valid4), 0);
    check("bp_after_ready", 32'(in_ready4), 1);
    issue4(OP_OR, 12, 3);
    wait_valid4("or_latency", 1);
    check("or_result", 32'(result4), 15);
    take4();

    // Illegal opcode, then a legal op clears err
    issue4(13, 5, 5);
    wait_valid4("ill_latency", 1);
    check("ill_err", 32'(err4), 1);
    check("ill_result", 32'(result4), 0);
    take4();
    issue4(OP_ADD, 1, 1);
    wait_valid4("ill_next_latency", 1);
    check("ill_next_err", 32'(err4), 0);
    check("ill_next_result", 32'(result4), 2);
    take4();

    // Reset in the middle of a MUL (status is 1 beforehand)
    issue4(OP_MUL, 7, 7);
    @(posedge clk); #1;
    rst = 1'b1;
    q4.delete();
    status_m = 0;
    #1;
    check("mrst_out_valid", 32'(out_valid4), 0);
    check("mrst_result", 32'(result4), 0);
    check("mrst_status", 32'(status4), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_in_ready", 32'(in_ready4), 1);
    check("mrst_out_valid2", 32'(out_valid4), 0);

    // Sweep every opcode (plus illegal ones) through the model
    for (int op = 0; op < 16; op++) begin
      for (int p = 0; p < 3; p++) begin
        run4(op, pairs_x[p], pairs_y[p]);
      end
    end
    // Shift and negate edge cases
    run4(OP_NEG, 8, 8);
    run4(OP_NEG, 0, 0);
    run4(OP_SHL, 9, 1);
    run4(OP_SHR, 3, 1);
    run4(OP_SHL, 3, 4);
    run4(OP_SHR, 8, 4);
    run4(OP_LT, 2, 3);
    run4(OP_EQ, 4, 5);

    // W=8 shifts
    run8(OP_SHL, 1, 9, 0, 0);
    run8(OP_SHL, 1, 7, 128, 0);
    run8(OP_SHR, 128, 7, 1, 0);
    run8(OP_SHL, 129, 1, 2, 1);

    repeat (2) @(posedge clk);
    check("final_queue_empty", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
